// File: rtl/clk_div_bank.sv
// clk_div_bank: PLL lock supervisor gating a bank of programmable
// clock-enable dividers. Each lane emits a one-cycle ce every P cycles and a
// 50% square wave; divisor changes only take effect at period boundaries.

module clk_div_lane #(
  parameter int DW      = 16,
  parameter int DEF_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          wr,
  input  logic [DW-1:0] val,
  output logic          ce,
  output logic          tgl
);
  logic [DW-1:0] act_div;
  logic [DW-1:0] shd_div;
  logic [DW-1:0] cnt;
  logic [DW-1:0] act_last;
  logic [DW-1:0] shd_last;
  logic          live;
  logic          wrap;

  // Last count value of a period; divisors 0 and 1 both give a 1-cycle period.
  assign act_last = (act_div == '0) ? '0 : act_div - 1'b1;
  assign shd_last = (shd_div == '0) ? '0 : shd_div - 1'b1;
  // A period starts on the first running edge or when the counter leaves its last value.
  assign wrap     = !live || (cnt == act_last);

  // Counter, ce pulse, square wave and shadow-to-active divisor transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_div <= DW'(DEF_DIV);
      shd_div <= DW'(DEF_DIV);
      cnt     <= '0;
      ce      <= 1'b0;
      tgl     <= 1'b0;
      live    <= 1'b0;
    end else begin
      if (wr) shd_div <= val;
      if (!run) begin
        // Idle lanes track the shadow so the next start uses the latest divisor.
        act_div <= shd_div;
        cnt     <= '0;
        ce      <= 1'b0;
        tgl     <= 1'b0;
        live    <= 1'b0;
      end else begin
        live <= 1'b1;
        tgl  <= tgl ^ ce;
        if (wrap) begin
          // Old shadow value is used here, so a write on this edge waits one period.
          act_div <= shd_div;
          cnt     <= '0;
          ce      <= (shd_last == '0);
        end else begin
          cnt <= cnt + 1'b1;
          ce  <= ((cnt + 1'b1) == act_last);
        end
      end
    end
  end
endmodule

module clk_div_bank #(
  parameter int NCH      = 2,
  parameter int DW       = 16,
  parameter int LOCK_CYC = 1024,
  parameter int DEF_DIV  = 4
) (
  input  logic           sys_clk,
  input  logic           rst,
  input  logic           pll_lock,
  input  logic [NCH-1:0] en,
  input  logic           div_wr,
  input  logic [2:0]     div_sel,
  input  logic [DW-1:0]  div_val,
  output logic [NCH-1:0] ce,
  output logic [NCH-1:0] tgl,
  output logic           ready,
  output logic           rst_out
);
  localparam int LW = $clog2(LOCK_CYC);

  typedef enum logic [1:0] {WAIT_LOCK, COUNT, READY} state_t;

  state_t        state;
  logic [LW-1:0] lock_cnt;
  logic          run_ok;

  // Lanes stop on the same edge that ready falls, so include pll_lock here.
  assign run_ok = ready & pll_lock;

  // Lock supervisor: release after LOCK_CYC uninterrupted locked edges.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= WAIT_LOCK;
      lock_cnt <= '0;
      ready    <= 1'b0;
      rst_out  <= 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          lock_cnt <= '0;
          if (pll_lock) state <= COUNT;
        end
        COUNT: begin
          if (!pll_lock) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
          end else if (lock_cnt == LW'(LOCK_CYC - 1)) begin
            state   <= READY;
            ready   <= 1'b1;
            rst_out <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        READY: begin
          if (!pll_lock) begin
            state    <= WAIT_LOCK;
            lock_cnt <= '0;
            ready    <= 1'b0;
            rst_out  <= 1'b1;
          end
        end
        default: begin
          state    <= WAIT_LOCK;
          lock_cnt <= '0;
          ready    <= 1'b0;
          rst_out  <= 1'b1;
        end
      endcase
    end
  end

  // One divider lane per channel; selects beyond NCH never match a lane.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    clk_div_lane #(
      .DW      (DW),
      .DEF_DIV (DEF_DIV)
    ) u_lane (
      .clk (sys_clk),
      .rst (rst),
      .run (en[gi] & run_ok),
      .wr  (div_wr && (div_sel == 3'(gi))),
      .val (div_val),
      .ce  (ce[gi]),
      .tgl (tgl[gi])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed scenarios plus random traffic, every cycle
// compared against an event-schedule reference model of the bank.

module tb_clk_div_bank;
  localparam int NCH = 2, DW = 16, LOCK_CYC = 16, DEF_DIV = 4;

  logic           sys_clk = 1'b0;
  logic           rst, pll_lock, div_wr;
  logic [NCH-1:0] en;
  logic [2:0]     div_sel;
  logic [DW-1:0]  div_val;
  logic [NCH-1:0] ce, tgl;
  logic           ready, rst_out;

  always #5 sys_clk = ~sys_clk;

  clk_div_bank #(.NCH(NCH), .DW(DW), .LOCK_CYC(LOCK_CYC), .DEF_DIV(DEF_DIV)) dut (
    .sys_clk (sys_clk), .rst (rst), .pll_lock (pll_lock), .en (en),
    .div_wr (div_wr), .div_sel (div_sel), .div_val (div_val),
    .ce (ce), .tgl (tgl), .ready (ready), .rst_out (rst_out)
  );

  int n_chk = 0, n_pass = 0;

  // Reference model: lock run length, per-channel shadow divisor and
  // scheduled edge numbers of the next ce and of the period end.
  int t = 0;
  int lock_run = 0;
  bit m_ready = 0;
  int m_s[NCH], m_nce[NCH], m_pend[NCH];
  bit m_idle[NCH], m_ce[NCH], m_tgl[NCH];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, t);
  endtask

  task automatic model_edge();
    int p;
    t++;
    if (rst) begin
      lock_run = 0;
      m_ready  = 0;
      for (int i = 0; i < NCH; i++) begin
        m_s[i] = DEF_DIV; m_idle[i] = 1; m_ce[i] = 0; m_tgl[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!(en[i] && m_ready && pll_lock)) begin
          m_idle[i] = 1; m_ce[i] = 0; m_tgl[i] = 0;
        end else begin
          m_tgl[i] = m_tgl[i] ^ m_ce[i];
          if (m_idle[i] || t == m_pend[i]) begin
            p = (m_s[i] > 1) ? m_s[i] : 1;
            m_nce[i]  = t + p - 1;
            m_pend[i] = t + p;
            m_idle[i] = 0;
          end
          m_ce[i] = (t == m_nce[i]);
        end
      end
      if (div_wr && div_sel < NCH) m_s[div_sel] = int'(div_val);
      lock_run = pll_lock ? ((lock_run < 1000000) ? lock_run + 1 : lock_run) : 0;
      m_ready  = (lock_run > LOCK_CYC);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("ready", ready, m_ready);
    chk("rst_out", rst_out, !m_ready);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("ce%0d", i), ce[i], m_ce[i]);
      chk($sformatf("tgl%0d", i), tgl[i], m_tgl[i]);
    end
  endtask

  // Ticks until ce[ch] is seen high; -1 if it never shows within the budget.
  task automatic wait_ce(input int ch, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ce[ch] && n < 64);
    if (!ce[ch]) n = -1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < 200);
    if (!ready) n = -1;
  endtask

  task automatic wr_div(input int sel, input int val);
    div_wr = 1; div_sel = 3'(sel); div_val = DW'(val);
    tick();
    div_wr = 0;
  endtask

  initial begin
    int n, cnt_ce, cnt_tg;
    logic tg_prev;
    rst = 1; pll_lock = 1; en = '0; div_wr = 0; div_sel = '0; div_val = '0;
    for (int i = 0; i < NCH; i++) begin
      m_s[i] = DEF_DIV; m_idle[i] = 1; m_ce[i] = 0; m_tgl[i] = 0; m_nce[i] = 0; m_pend[i] = 0;
    end
    repeat (3) tick();
    chk("rst_ready", ready, 0);
    chk("rst_rst_out", rst_out, 1);
    chk("rst_ce", int'(ce), 0);
    chk("rst_tgl", int'(tgl), 0);

    // Lock latency from reset release: first sampling edge + LOCK_CYC.
    rst = 0;
    wait_ready(n);
    chk("lock_lat", n, LOCK_CYC + 1);

    // Glitch during counting restarts the count.
    rst = 1; tick(); rst = 0;
    repeat (9) tick();
    pll_lock = 0; tick(); pll_lock = 1;
    wait_ready(n);
    chk("relock_lat", n, LOCK_CYC + 1);

    // Channel 0 at default divisor; channel 1 stays quiet.
    en = 2'b01;
    wait_ce(0, n); chk("first_ce", n, DEF_DIV);
    wait_ce(0, n); chk("ce_gap_def", n, DEF_DIV);
    repeat (12) tick();
    chk("ch1_quiet", {30'b0, ce[1], tgl[1]}, 0);

    // Mid-period write: current period finishes at 4, then 7 apart.
    wait_ce(0, n);
    tick(); tick();
    wr_div(0, 7);
    wait_ce(0, n); chk("ce_finish_old", n, 1);
    wait_ce(0, n); chk("ce_gap_7a", n, 7);
    wait_ce(0, n); chk("ce_gap_7b", n, 7);

    // Write on the wrap edge applies one period later.
    wr_div(0, 5);
    wait_ce(0, n); chk("ce_wrap_wr_old", n, 6);
    wait_ce(0, n); chk("ce_wrap_wr_new", n, 5);

    // Divisor 0 then 1: continuous ce, tgl toggles every cycle.
    for (int v = 0; v < 2; v++) begin
      wr_div(0, v);
      repeat (8) tick();
      cnt_ce = 0; cnt_tg = 0; tg_prev = tgl[0];
      for (int k = 0; k < 8; k++) begin
        tick();
        cnt_ce += int'(ce[0]);
        cnt_tg += int'(tgl[0] != tg_prev);
        tg_prev = tgl[0];
      end
      chk($sformatf("ce_cont_div%0d", v), cnt_ce, 8);
      chk($sformatf("tgl_cont_div%0d", v), cnt_tg, 8);
    end

    // Out-of-range select is ignored; channel 1 keeps the default.
    wr_div(5, 9);
    en = 2'b10;
    wait_ce(1, n); chk("sel5_first", n, DEF_DIV);
    wait_ce(1, n); chk("sel5_gap", n, DEF_DIV);

    // Lock loss while running drops everything on the next edge.
    en = 2'b11;
    repeat (5) tick();
    pll_lock = 0; tick();
    chk("drop_ready", ready, 0);
    chk("drop_rst_out", rst_out, 1);
    chk("drop_ce", int'(ce), 0);
    chk("drop_tgl", int'(tgl), 0);
    pll_lock = 1;
    wait_ready(n);
    chk("drop_relock", n, LOCK_CYC + 1);

    // Reset mid-run with a write in the reset cycle: divisors back to default.
    wr_div(0, 3);
    repeat (6) tick();
    rst = 1; div_wr = 1; div_sel = 3'd0; div_val = 16'd9;
    tick();
    rst = 0; div_wr = 0;
    en = 2'b01;
    wait_ready(n);
    chk("rst_relock", n, LOCK_CYC + 1);
    wait_ce(0, n); chk("rst_first_ce", n, DEF_DIV);
    wait_ce(0, n); chk("rst_gap", n, DEF_DIV);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      rst      = ($urandom_range(0, 999) == 0);
      pll_lock = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) en = NCH'($urandom);
      div_wr   = ($urandom_range(0, 5) == 0);
      div_sel  = 3'($urandom_range(0, 7));
      div_val  = DW'($urandom_range(0, 9));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 2: number of divider channels, 1..8.
REQ-002 Parameter DW, default 16: divisor width in bits.
REQ-003 Parameter LOCK_CYC, default 1024: consecutive locked cycles required before release, >=2.
REQ-004 Parameter DEF_DIV, default 4: divisor loaded into every channel at reset.
REQ-005 sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pll_lock  in  1  PLL lock indication, treated as already synchronous to sys_clk.
REQ-008 en  in  NCH  per-channel run enable.
REQ-009 div_wr  in  1  one-cycle divisor write strobe.
REQ-010 div_sel  in  3  channel index for div_wr.
REQ-011 div_val  in  DW  divisor value for div_wr.
REQ-012 ce  out  NCH  per-channel one-cycle clock-enable pulse.
REQ-013 tgl  out  NCH  per-channel square wave, toggles on each ce.
REQ-014 ready  out  1  lock-supervisor released.
REQ-015 rst_out  out  1  registered downstream reset, equals ~ready.

Function
REQ-016 Supervisor states SHALL be WAIT_LOCK, COUNT, READY.
REQ-017 WAIT_LOCK: lock counter held at 0; pll_lock=1 -> COUNT.
REQ-018 COUNT: counter increments per cycle with pll_lock=1; pll_lock=0 -> WAIT_LOCK, counter cleared.
REQ-019 ready SHALL assert exactly LOCK_CYC cycles after the first edge sampling pll_lock=1, provided pll_lock stayed high throughout.
REQ-020 READY: pll_lock=0 SHALL drop ready on the next edge and return to WAIT_LOCK.
REQ-021 Each channel holds active divisor D and shadow S; effective period P = max(D,1) cycles (0 and 1 both mean every cycle).
REQ-022 Running channel: counter counts 0..P-1 then wraps to 0; ce=1 in the cycle counter equals P-1.
REQ-023 A channel SHALL run only when en[i]=1 and ready=1; otherwise counter=0, ce[i]=0, tgl[i]=0.
REQ-024 tgl[i] SHALL invert on the edge following each ce[i] pulse, so tgl period = 2P cycles, 50% duty.
REQ-025 div_wr with div_sel<NCH SHALL load S of that channel on the next edge; div_sel>=NCH SHALL be ignored.
REQ-026 S SHALL transfer to D at the wrap edge (counter P-1 -> 0) of a running channel, or immediately when the channel is not running; no truncated or stretched period.
REQ-027 div_wr coinciding with the wrap edge SHALL apply the new value at the following wrap; the ongoing period keeps old P.
REQ-028 Newly enabled channel SHALL produce its first ce P cycles after the enable edge.
REQ-029 Channels SHALL be fully independent; simultaneous ce on several channels permitted.
REQ-030 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-031 rst=1 SHALL force: state WAIT_LOCK, lock counter 0, ready=0, rst_out=1, all ce=0, all tgl=0, all counters 0, all D=S=DEF_DIV.
REQ-032 rst asserted mid-operation SHALL take effect on the next edge regardless of pll_lock, en or div_wr; div_wr in the reset cycle is discarded.
REQ-033 After rst deasserts, ready SHALL not assert earlier than LOCK_CYC cycles later.

Verification
REQ-034 LOCK_CYC=16, pll_lock=1 from reset release -> ready=1, rst_out=0 exactly 16 cycles later; pll_lock glitch low at cycle 10 -> count restarts, ready at 16 cycles after relock.
REQ-035 ready=1, en=01, DEF_DIV=4 -> ce[0] every 4th cycle, first 4 cycles after enable; tgl[0] period 8; ce[1]=tgl[1]=0.
REQ-036 Channel 0 running P=4, write div_val=7 mid-period -> current period completes at 4, all subsequent ce spaced 7.
REQ-037 div_val=0 and div_val=1 -> ce continuously high, tgl toggles every cycle; div_sel=5 with NCH=2 -> no divisor change.
REQ-038 Running with ready=1, drop pll_lock -> next edge ready=0, rst_out=1, ce=0, tgl=0; rst mid-run -> all D back to 4.
